// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM responder and its clear engine.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

endpackage

// File: rtl/ram_if.sv
// Dual-port byte RAM bus: masters drive address/write/enable, the responder drives read data.
interface ram_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [BYTE_WIDTH-1:0] write_a;
    logic                  write_en_a;
    logic [BYTE_WIDTH-1:0] data_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [BYTE_WIDTH-1:0] write_b;
    logic                  write_en_b;
    logic [BYTE_WIDTH-1:0] data_b;

    modport s (
        input  addr_a, write_a, write_en_a,
        input  addr_b, write_b, write_en_b,
        output data_a, data_b
    );

    modport m (
        output addr_a, write_a, write_en_a,
        output addr_b, write_b, write_en_b,
        input  data_a, data_b
    );
endinterface

// File: rtl/ram_clear_fsm.sv
// Clear engine: sweeps every address once after reset or on request, then reports READY.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear_req,
    output logic                  o_init_done,
    output logic                  o_clr_active,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic                  o_clr_we
);

    ram_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_cnt       <= '0;
            r_init_done <= (CLEAR_ON_RESET == 0);
        end else begin
            case (r_state)
                CLEAR: begin
                    // Counter wraps to zero on the final write, ready for the next clear.
                    r_cnt <= r_cnt + 1'b1;
                    if (&r_cnt) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    if (i_clear_req) begin
                        r_state     <= CLEAR;
                        r_cnt       <= '0;
                        r_init_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_init_done  = r_init_done;
    assign o_clr_active = (r_state == CLEAR);
    assign o_clr_we     = (r_state == CLEAR);
    assign o_clr_addr   = r_cnt;

endmodule

// File: rtl/ram_dp_responder.sv
// True dual-port byte RAM on the responder side of ram_if, with a built-in zeroing engine.
module ram_dp_responder
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int BYTE_WIDTH     = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic clk,
    input  logic rst_n,
    ram_if.s     ram,
    input  logic clear_req,
    output logic init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [BYTE_WIDTH-1:0] r_mem [DEPTH];
    logic [BYTE_WIDTH-1:0] r_data_a;
    logic [BYTE_WIDTH-1:0] r_data_b;

    logic                  w_clr_active;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_port_we_a;
    logic                  w_port_we_b;
    logic                  w_mem_we_b;

    ram_clear_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear_req  (clear_req),
        .o_init_done  (init_done),
        .o_clr_active (w_clr_active),
        .o_clr_addr   (w_clr_addr),
        .o_clr_we     (w_clr_we)
    );

    assign w_port_we_a = ram.write_en_a & ~w_clr_active;
    assign w_port_we_b = ram.write_en_b & ~w_clr_active;
    // Port a owns the location when both ports write the same address together.
    assign w_mem_we_b  = w_port_we_b & ~(w_port_we_a && (ram.addr_a == ram.addr_b));

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_port_we_a) begin
                r_mem[ram.addr_a] <= ram.write_a;
            end
            if (w_mem_we_b) begin
                r_mem[ram.addr_b] <= ram.write_b;
            end
        end
    end

    // Write-first on the own port; the array read sees pre-edge contents, so cross-port is read-first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else if (w_clr_active) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_data_a <= w_port_we_a ? ram.write_a : r_mem[ram.addr_a];
            r_data_b <= w_port_we_b ? ram.write_b : r_mem[ram.addr_b];
        end
    end

    assign ram.data_a = r_data_a;
    assign ram.data_b = r_data_b;

endmodule

// File: tb/tb_ram_dp_responder.sv
// Directed bench for ram_dp_responder: clear timing, port semantics, collisions, reset-mid-clear.
module tb_ram_dp_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    logic clear_req;
    logic clear_req1;
    logic init_done;
    logic init_done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_if #(.ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus0 ();
    ram_if #(.ADDR_WIDTH(4), .BYTE_WIDTH(8)) bus1 ();

    ram_dp_responder #(.ADDR_WIDTH(4), .BYTE_WIDTH(8), .CLEAR_ON_RESET(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ram       (bus0.s),
        .clear_req (clear_req),
        .init_done (init_done)
    );

    ram_dp_responder #(.ADDR_WIDTH(4), .BYTE_WIDTH(8), .CLEAR_ON_RESET(0)) dut_nc (
        .clk       (clk),
        .rst_n     (rst1_n),
        .ram       (bus1.s),
        .clear_req (clear_req1),
        .init_done (init_done1)
    );

    typedef struct {
        logic       we_a;
        logic [3:0] addr_a;
        logic [7:0] wr_a;
        logic       we_b;
        logic [3:0] addr_b;
        logic [7:0] wr_b;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic we_a, input logic [3:0] addr_a, input logic [7:0] wr_a,
                          input logic we_b, input logic [3:0] addr_b, input logic [7:0] wr_b);
        bus0.write_en_a = we_a;
        bus0.addr_a     = addr_a;
        bus0.write_a    = wr_a;
        bus0.write_en_b = we_b;
        bus0.addr_b     = addr_b;
        bus0.write_b    = wr_b;
    endtask

    // Counts cycles from now until init_done rises; 0 means it never rose within the budget.
    task automatic wait_init(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic read_all_zero(input string name);
        int bad;
        bad = 0;
        drive0(1'b0, 4'd0, 8'h00, 1'b0, 4'd15, 8'h00);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus0.data_a !== 8'h00 || bus0.data_b !== 8'h00) bad++;
            bus0.addr_a = 4'(i + 1);
            bus0.addr_b = 4'(14 - i);
        end
        check(name, bad, 0);
    endtask

    initial begin
        int cyc;
        int bad;

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd3,  8'h00, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 1'b0, 4'd3,  8'h00, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 4'd7,  8'h11, 1'b1, 4'd7,  8'h22, 8'h11, 8'h22};
        vecs[3] = '{1'b0, 4'd7,  8'h00, 1'b0, 4'd7,  8'h00, 8'h11, 8'h11};
        vecs[4] = '{1'b0, 4'd5,  8'h00, 1'b1, 4'd5,  8'h3C, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 4'd5,  8'h00, 1'b0, 4'd5,  8'h00, 8'h3C, 8'h3C};
        vecs[6] = '{1'b1, 4'd15, 8'h7E, 1'b1, 4'd0,  8'h81, 8'h7E, 8'h81};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd15, 8'h00, 8'h81, 8'h7E};

        rst_n = 1'b0; rst1_n = 1'b0; clear_req = 1'b0; clear_req1 = 1'b0;
        drive0(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        bus1.write_en_a = 1'b0; bus1.addr_a = 4'd0; bus1.write_a = 8'h00;
        bus1.write_en_b = 1'b0; bus1.addr_b = 4'd0; bus1.write_b = 8'h00;
        repeat (3) @(negedge clk);

        check("reset_data_a", bus0.data_a, 8'h00);
        check("reset_data_b", bus0.data_b, 8'h00);
        check("reset_init_done", init_done, 1'b0);
        check("nc_reset_init_done", init_done1, 1'b1);

        rst_n = 1'b1;
        wait_init(cyc);
        $display("initial clear: init_done after %0d cycles", cyc);
        check("initial_clear_cycles", cyc, 16);
        read_all_zero("initial_clear_zero");

        for (int v = 0; v < 8; v++) begin
            drive0(vecs[v].we_a, vecs[v].addr_a, vecs[v].wr_a,
                   vecs[v].we_b, vecs[v].addr_b, vecs[v].wr_b);
            @(negedge clk);
            $display("vec %0d: data_a=%h data_b=%h", v, bus0.data_a, bus0.data_b);
            check($sformatf("vec%0d_data_a", v), bus0.data_a, vecs[v].exp_a);
            check($sformatf("vec%0d_data_b", v), bus0.data_b, vecs[v].exp_b);
        end

        for (int i = 0; i < 16; i++) begin
            drive0(1'b1, 4'(i), 8'hFF, 1'b0, 4'd0, 8'h00);
            @(negedge clk);
        end
        drive0(1'b0, 4'd9, 8'h00, 1'b0, 4'd2, 8'h00);
        @(negedge clk);
        $display("fill: data_a=%h data_b=%h", bus0.data_a, bus0.data_b);
        check("fill_readback_a", bus0.data_a, 8'hFF);
        check("fill_readback_b", bus0.data_b, 8'hFF);

        // Request a clear while hammering both ports with writes and reads of 0xFF data.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        bad = 0;
        check("clear_req_init_low", init_done, 1'b0);
        for (int k = 2; k <= 17; k++) begin
            drive0(1'b1, 4'(k), 8'h5A, 1'b1, 4'(k + 3), 8'hA5);
            if (k == 6) clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            if (bus0.data_a !== 8'h00 || bus0.data_b !== 8'h00) bad++;
            if (k < 17 && init_done !== 1'b0) bad++;
            if (k == 17) check("clear_req_init_high", init_done, 1'b1);
        end
        drive0(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00);
        $display("clear request: %0d bad samples during clear", bad);
        check("clear_dead_ports", bad, 0);
        read_all_zero("clear_req_zero");

        // Reset in the middle of a clear restarts the sweep from address 0.
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midclear_reset_init", init_done, 1'b0);
        check("midclear_reset_data", bus0.data_a, 8'h00);
        rst_n = 1'b1;
        wait_init(cyc);
        $display("mid-clear reset: init_done after %0d cycles", cyc);
        check("midclear_restart_cycles", cyc, 16);

        // Variant without clear-on-reset: immediately usable, wrap address 15.
        rst1_n = 1'b1;
        @(negedge clk);
        check("nc_init_after_release", init_done1, 1'b1);
        bus1.write_en_a = 1'b1; bus1.addr_a = 4'd15; bus1.write_a = 8'h9C;
        @(negedge clk);
        bus1.write_en_a = 1'b0; bus1.addr_b = 4'd15;
        @(negedge clk);
        $display("nc addr15: data_b=%h", bus1.data_b);
        check("nc_addr15_readback", bus1.data_b, 8'h9C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
